// File: rtl/clk_lock_pkg.sv
// clk_lock_pkg: FSM state type, lock-counter default and effective-divisor helper for clk_lock_divider
package clk_lock_pkg;
  typedef enum logic [1:0] {RST, WAIT, LOCKED} state_t;
  localparam int LOCK_CYCLES_DEF = 1024;
  function automatic logic [31:0] div_eff(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction
endpackage

// File: rtl/clk_lock_divider_ce_divider.sv
// ce_divider: one glitchless clock-enable channel; in clki/rst_n/lock/load/val, out ce (wrap strobe) and ack (divisor applied)
module ce_divider import clk_lock_pkg::*; #(
  parameter int DIV_W = 16,
  parameter int DIV_RESET = 24
) (
  input  logic             clki,
  input  logic             rst_n,
  input  logic             lock,
  input  logic             load,
  input  logic [DIV_W-1:0] val,
  output logic             ce,
  output logic             ack
);
  logic [DIV_W-1:0] div, pend_val, phase;
  logic pend;
  assign ce = lock && (32'(phase) == div_eff(32'(div)) - 32'd1);
  always_ff @(posedge clki or negedge rst_n)
    if (!rst_n) begin
      div <= DIV_W'(DIV_RESET);
      pend_val <= '0;
      pend <= 1'b0;
      phase <= '0;
      ack <= 1'b0;
    end else begin
      ack <= (ce && pend) || (load && !lock);
      div <= (load && !lock) ? val : (ce && pend) ? pend_val : div;
      pend <= lock ? (load || (pend && !ce)) : (pend && !load);
      pend_val <= load ? val : pend_val;
      phase <= (!lock || ce) ? '0 : phase + 1'b1;
    end
endmodule

// File: rtl/clk_lock_divider.sv
// clk_lock_divider: lock qualifier, synchronised fabric reset and NUM_CH ce dividers; in clki/rst_n/mcu_rst/div_val/div_load, out div_ack/lock/rst_out_n/ce, plus loss_cnt when LOSS_CNT_EN is defined
module clk_lock_divider import clk_lock_pkg::*; #(
  parameter int NUM_CH = 2,
  parameter int DIV_W = 16,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int DIV_RESET = 24
) (
  input  logic                    clki,
  input  logic                    rst_n,
  input  logic                    mcu_rst,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
  output logic [NUM_CH-1:0]       div_ack,
  output logic                    lock,
  output logic                    rst_out_n,
  output logic [NUM_CH-1:0]       ce
`ifdef LOSS_CNT_EN
  , output logic [7:0]            loss_cnt
`endif
);
  localparam int LCW = $clog2(LOCK_CYCLES);
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic [LCW-1:0] cnt;
  logic mcu_rst_s;
  assign mcu_rst_s = sync[SYNC_STAGES-1];
  always_comb begin
    state_n = mcu_rst_s ? RST : (state == RST) ? WAIT :
              (state == WAIT && cnt == LCW'(LOCK_CYCLES - 1)) ? LOCKED : state;
  end
  always_ff @(posedge clki or negedge rst_n)
    if (!rst_n) begin
      sync <= '1;
      state <= RST;
      cnt <= '0;
      lock <= 1'b0;
      rst_out_n <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], mcu_rst};
      state <= state_n;
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      lock <= state_n == LOCKED;
      rst_out_n <= state_n == LOCKED;
    end
`ifdef LOSS_CNT_EN
  always_ff @(posedge clki or negedge rst_n)
    if (!rst_n) loss_cnt <= '0;
    else if (state == LOCKED && state_n != LOCKED && loss_cnt != 8'hff) loss_cnt <= loss_cnt + 1'b1;
`endif
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ce_divider #(.DIV_W(DIV_W), .DIV_RESET(DIV_RESET)) u_div (
      .clki(clki),
      .rst_n(rst_n),
      .lock(lock),
      .load(div_load[g]),
      .val(div_val[g*DIV_W +: DIV_W]),
      .ce(ce[g]),
      .ack(div_ack[g])
    );
  end
endmodule
